// File: rtl/dec_pkg.sv
// Shared types and constants for the decoder frame scheduler.
package dec_pkg;

  localparam int DEC_WORD_W       = 64;
  localparam int DEC_FRAME_WORDS  = 262;
  localparam int DEC_OUT_WORDS    = 8;
  localparam int DEC_MAX_INFLIGHT = 2;
  localparam int DEC_GAP_CYCLES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dec_out_stage.sv
// Output stage: drains the decoder tx FWFT FIFO into a registered valid/ready
// port, tags frame ends with m_last and reports completed frames.
module dec_out_stage
  import dec_pkg::*;
#(
  parameter int OUT_WORDS = DEC_OUT_WORDS
) (
  input  logic                  clk_dp,
  input  logic                  rst_n,
  output logic                  tx_dat_fifo_rden,
  input  logic [DEC_WORD_W-1:0] tx_dat_fifo_dout,
  input  logic                  tx_dat_fifo_empty,
  output logic [DEC_WORD_W-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  frame_done
);

  localparam int OCNT_W = cnt_w(OUT_WORDS);

  logic [OCNT_W-1:0]     ocnt;
  logic [DEC_WORD_W-1:0] data_p1;
  logic                  vld_p1;
  logic                  last_p1;
  logic                  ocnt_wrap;

  assign ocnt_wrap        = (ocnt == OCNT_W'(OUT_WORDS - 1));
  assign tx_dat_fifo_rden = !tx_dat_fifo_empty && (!vld_p1 || m_ready);

  // Stage p1: FIFO head captured into the output register
  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      ocnt    <= '0;
    end else if (tx_dat_fifo_rden) begin
      data_p1 <= tx_dat_fifo_dout;
      vld_p1  <= 1'b1;
      last_p1 <= ocnt_wrap;
      ocnt    <= ocnt_wrap ? '0 : ocnt + 1'b1;
    end else if (vld_p1 && m_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign m_data     = data_p1;
  assign m_valid    = vld_p1;
  assign m_last     = last_p1;
  assign frame_done = vld_p1 && m_ready && last_p1;

endmodule

// File: rtl/dec_frame_sched.sv
// Frame scheduler in front of decoder_top: frames the LLR stream into the rx
// FIFO under a credit limit and drains decoded frames. Optional statistics
// counters are built when DEC_SCHED_STATS_EN is defined.
module dec_frame_sched
  import dec_pkg::*;
#(
  parameter int FRAME_WORDS  = DEC_FRAME_WORDS,
  parameter int OUT_WORDS    = DEC_OUT_WORDS,
  parameter int MAX_INFLIGHT = DEC_MAX_INFLIGHT,
  parameter int GAP_CYCLES   = DEC_GAP_CYCLES
) (
  input  logic                               clk_dp,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic [DEC_WORD_W-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               rx_dat_fifo_wren,
  output logic [DEC_WORD_W-1:0]              rx_dat_fifo_din,
  input  logic                               rx_dat_fifo_full,
  output logic                               tx_dat_fifo_rden,
  input  logic [DEC_WORD_W-1:0]              tx_dat_fifo_dout,
  input  logic                               tx_dat_fifo_empty,
  output logic [DEC_WORD_W-1:0]              m_data,
  output logic                               m_valid,
  output logic                               m_last,
  input  logic                               m_ready,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  credits,
  output logic                               busy,
  output logic                               err_underflow
`ifdef DEC_SCHED_STATS_EN
  ,
  output logic [31:0]                        stat_frames_in,
  output logic [31:0]                        stat_frames_out,
  output logic [31:0]                        stat_full_stall
`endif
);

  localparam int WCNT_W = cnt_w(FRAME_WORDS);
  localparam int GCNT_W = cnt_w(GAP_CYCLES);
  localparam int CRED_W = $clog2(MAX_INFLIGHT + 1);

  sched_state_t      state;
  logic [WCNT_W-1:0] wcnt;
  logic [GCNT_W-1:0] gcnt;
  logic              accept;
  logic              cred_inc;
  logic              frame_done;

  assign s_ready          = (state == ST_LOAD) && !rx_dat_fifo_full;
  assign accept           = s_valid && s_ready;
  assign rx_dat_fifo_wren = accept;
  assign rx_dat_fifo_din  = s_data;
  assign cred_inc         = accept && (wcnt == WCNT_W'(FRAME_WORDS - 1));
  assign busy             = (credits != '0) || (state != ST_IDLE);

  // Input FSM: a started frame always runs to completion, enable only gates starts
  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      gcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wcnt <= '0;
          if (enable && (credits < CRED_W'(MAX_INFLIGHT))) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cred_inc) begin
            wcnt  <= '0;
            gcnt  <= '0;
            state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
          end else if (accept) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == GCNT_W'(GAP_CYCLES - 1)) begin
            gcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credit counter: a load and a drain in the same cycle cancel out
  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      credits       <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (frame_done && (credits == '0)) err_underflow <= 1'b1;
      case ({cred_inc, frame_done})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   if (credits != '0) credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  dec_out_stage #(
    .OUT_WORDS (OUT_WORDS)
  ) u_out_stage (
    .clk_dp            (clk_dp),
    .rst_n             (rst_n),
    .tx_dat_fifo_rden  (tx_dat_fifo_rden),
    .tx_dat_fifo_dout  (tx_dat_fifo_dout),
    .tx_dat_fifo_empty (tx_dat_fifo_empty),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_last            (m_last),
    .m_ready           (m_ready),
    .frame_done        (frame_done)
  );

`ifdef DEC_SCHED_STATS_EN
  always_ff @(posedge clk_dp or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_in  <= '0;
      stat_frames_out <= '0;
      stat_full_stall <= '0;
    end else begin
      if (cred_inc)   stat_frames_in  <= stat_frames_in + 1'b1;
      if (frame_done) stat_frames_out <= stat_frames_out + 1'b1;
      if ((state == ST_LOAD) && s_valid && rx_dat_fifo_full)
        stat_full_stall <= stat_full_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_frame_sched.sv
// Directed plus randomized bench for dec_frame_sched with a queue-based
// reference model of the rx stream, tx FIFO and frames in flight.
module tb_dec_frame_sched;

  localparam int FW = 4;
  localparam int OW = 2;
  localparam int MI = 2;
  localparam int GC = 3;

  logic        clk_dp = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        wren;
  logic [63:0] din;
  logic        full = 1'b0;
  logic        rden;
  logic [63:0] tx_dout = '0;
  logic        tx_empty = 1'b1;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic [1:0]  credits;
  logic        busy;
  logic        err_underflow;
`ifdef DEC_SCHED_STATS_EN
  logic [31:0] stat_frames_in, stat_frames_out, stat_full_stall;
`endif

  int nchk = 0;
  int nerr = 0;
  int out_frames = 0;
  logic [63:0] txq[$];
  logic [63:0] rxlog[$];
  logic [63:0] outlog[$];
  logic        outlast[$];
  logic [63:0] exp_out[$];
  logic [63:0] sentq[$];

  dec_frame_sched #(
    .FRAME_WORDS (FW), .OUT_WORDS (OW), .MAX_INFLIGHT (MI), .GAP_CYCLES (GC)
  ) dut (
    .clk_dp (clk_dp), .rst_n (rst_n), .enable (enable),
    .s_data (s_data), .s_valid (s_valid), .s_ready (s_ready),
    .rx_dat_fifo_wren (wren), .rx_dat_fifo_din (din), .rx_dat_fifo_full (full),
    .tx_dat_fifo_rden (rden), .tx_dat_fifo_dout (tx_dout), .tx_dat_fifo_empty (tx_empty),
    .m_data (m_data), .m_valid (m_valid), .m_last (m_last), .m_ready (m_ready),
    .credits (credits), .busy (busy), .err_underflow (err_underflow)
`ifdef DEC_SCHED_STATS_EN
    , .stat_frames_in (stat_frames_in), .stat_frames_out (stat_frames_out),
    .stat_full_stall (stat_full_stall)
`endif
  );

  always #5 clk_dp = ~clk_dp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge-side models: rx write log, output handshake log, FWFT tx FIFO.
  always @(posedge clk_dp) begin
    if (wren) begin
      rxlog.push_back(din);
      check("wr_while_full", 64'(full), 64'(0));
    end
    if (m_valid && m_ready) begin
      outlog.push_back(m_data);
      outlast.push_back(m_last);
      if (m_last) out_frames++;
    end
    if (rden && txq.size() > 0) void'(txq.pop_front());
    tx_empty <= (txq.size() == 0);
    tx_dout  <= (txq.size() != 0) ? txq[0] : 64'h0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_dp);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    s_data = w;
    s_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk_dp);
      acc = s_ready;
      waited++;
      step();
    end
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_wren"}, 64'(wren), 64'(0));
    check({tag, "_rden"}, 64'(rden), 64'(0));
    check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_m_last"}, 64'(m_last), 64'(0));
    check({tag, "_m_data"}, m_data, 64'(0));
    check({tag, "_credits"}, 64'(credits), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_err"}, 64'(err_underflow), 64'(0));
  endtask

  initial begin
    int w;
    int n;
    int rcnt;
    int acc_idx;
    int pushed;
    int in_fr;
    logic [63:0] rw;

    // Reset state
    step(); step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step(); step();

    // Basic load: four back-to-back words, credit after the fourth
    enable = 1'b1;
    for (int i = 1; i <= FW; i++) begin
      send_word(64'(i), w);
      if (i > 1) check("load_consecutive", 64'(w), 64'(1));
      if (i == FW - 1) check("credit_before_last", 64'(credits), 64'(0));
    end
    check("credit_after_frame1", 64'(credits), 64'(1));
    check("rx_count_frame1", 64'(rxlog.size()), 64'(FW));
    for (int i = 0; i < FW; i++) check("rx_data_frame1", rxlog[i], 64'(i + 1));

    // Gap plus one idle cycle before the next frame opens
    s_data = 64'd5;
    s_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_dp);
      if (s_ready) break;
      n++;
      step();
    end
    check("gap_ready_low_cycles", 64'(n), 64'(GC + 1));
    step();
    send_word(64'd6, w);

    // rx FIFO full mid-frame
    full = 1'b1;
    s_data = 64'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_dp);
      check("full_s_ready", 64'(s_ready), 64'(0));
      check("full_wren", 64'(wren), 64'(0));
      step();
    end
    full = 1'b0;
    send_word(64'd7, w);
    check("resume_after_full", 64'(w), 64'(1));
    send_word(64'd8, w);
    check("credit_after_frame2", 64'(credits), 64'(2));
    check("rx_count_frame2", 64'(rxlog.size()), 64'(2 * FW));
    for (int i = 0; i < 2 * FW; i++) check("rx_data_frame2", rxlog[i], 64'(i + 1));

    // Credit limit holds the FSM in IDLE
    s_data = 64'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_dp);
      check("limit_s_ready", 64'(s_ready), 64'(0));
      step();
    end
    check("limit_credits", 64'(credits), 64'(MI));
    check("limit_busy", 64'(busy), 64'(1));

    // Output backpressure: one read, head held
    txq.push_back(64'hA);
    txq.push_back(64'hB);
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_dp);
      if (rden) rcnt++;
      step();
    end
    check("bp_single_rden", 64'(rcnt), 64'(1));
    check("bp_m_valid", 64'(m_valid), 64'(1));
    check("bp_m_data", m_data, 64'hA);
    check("bp_m_last", 64'(m_last), 64'(0));
    m_ready = 1'b1;
    step();
    check("bp_second_data", m_data, 64'hB);
    check("bp_second_last", 64'(m_last), 64'(1));
    step();
    m_ready = 1'b0;
    check("drain_credit", 64'(credits), 64'(1));
    check("drain_outlog", 64'(outlog.size()), 64'(2));
    send_word(64'd9, w);
    check("third_frame_start", 64'(w), 64'(2));

    // Load completion and frame drain in the same cycle
    txq.push_back(64'hC);
    txq.push_back(64'hD);
    send_word(64'd10, w);
    send_word(64'd11, w);
    s_valid = 1'b0;
    step(); step(); step();
    check("sim_head_c", m_data, 64'hC);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("sim_head_d", m_data, 64'hD);
    check("sim_last_d", 64'(m_last), 64'(1));
    s_data = 64'd12;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk_dp);
    check("sim_ready", 64'(s_ready), 64'(1));
    step();
    check("sim_credits_hold", 64'(credits), 64'(1));
    check("sim_rx_last", rxlog[rxlog.size() - 1], 64'd12);

    // Underflow: drain two frames with one credit outstanding
    enable = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) txq.push_back(64'hE0 + 64'(i));
    for (int i = 0; i < 30 && out_frames < 4; i++) step();
    check("uf_frames_out", 64'(out_frames), 64'(4));
    check("uf_credits", 64'(credits), 64'(0));
    check("uf_err", 64'(err_underflow), 64'(1));
    check("uf_busy", 64'(busy), 64'(0));
    step();
    check("uf_err_sticky", 64'(err_underflow), 64'(1));

    // Reset in the middle of a frame
    m_ready = 1'b0;
    enable = 1'b1;
    send_word(64'h31, w);
    send_word(64'h32, w);
    s_data = 64'h33;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    step();
    @(negedge clk_dp);
    check("arst_no_write", 64'(wren), 64'(0));
    step();
    check("arst_rx_count", 64'(rxlog.size()), 64'(3 * FW + 2));
    rst_n = 1'b1;
    for (int i = 0; i < FW; i++) begin
      send_word(64'h41 + 64'(i), w);
      if (i == FW - 2) check("arst_wcnt_restart", 64'(credits), 64'(0));
    end
    check("arst_credit", 64'(credits), 64'(1));
    for (int i = 0; i < FW; i++)
      check("arst_rx_data", rxlog[3 * FW + 2 + i], 64'h41 + 64'(i));

    // Randomized traffic against the queue model
    s_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rxlog.delete();
    outlog.delete();
    outlast.delete();
    out_frames = 0;
    rst_n = 1'b1;
    step();
    acc_idx = 0;
    pushed = 0;
    for (int c = 0; c < 800; c++) begin
      if (acc_idx == sentq.size()) sentq.push_back({$urandom, $urandom});
      s_data  = sentq[acc_idx];
      s_valid = ($urandom_range(0, 3) != 0);
      full    = ($urandom_range(0, 4) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 9) != 0);
      in_fr = rxlog.size() / FW;
      if (in_fr > pushed && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < OW; k++) begin
          rw = {$urandom, $urandom};
          txq.push_back(rw);
          exp_out.push_back(rw);
        end
        pushed++;
      end
      @(negedge clk_dp);
      check("rand_credits", 64'(credits), 64'(rxlog.size() / FW - out_frames));
      if (full) check("rand_ready_full", 64'(s_ready), 64'(0));
      if (s_valid && s_ready) acc_idx++;
      step();
    end

    // Finish any partial frame, then drain everything
    enable = 1'b0;
    full = 1'b0;
    for (int i = 0; i < 60 && (rxlog.size() % FW) != 0; i++) begin
      if (acc_idx == sentq.size()) sentq.push_back({$urandom, $urandom});
      s_data = sentq[acc_idx];
      s_valid = 1'b1;
      @(negedge clk_dp);
      if (s_valid && s_ready) acc_idx++;
      step();
    end
    s_valid = 1'b0;
    while (pushed < rxlog.size() / FW) begin
      for (int k = 0; k < OW; k++) begin
        rw = {$urandom, $urandom};
        txq.push_back(rw);
        exp_out.push_back(rw);
      end
      pushed++;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 400 && out_frames < pushed; i++) step();
    step();
    check("rand_drain_frames", 64'(out_frames), 64'(pushed));
    check("rand_rx_count", 64'(rxlog.size()), 64'(acc_idx));
    for (int i = 0; i < rxlog.size() && i < acc_idx; i++)
      check("rand_rx_data", rxlog[i], sentq[i]);
    check("rand_out_count", 64'(outlog.size()), 64'(exp_out.size()));
    for (int i = 0; i < outlog.size() && i < exp_out.size(); i++) begin
      check("rand_out_data", outlog[i], exp_out[i]);
      check("rand_out_last", 64'(outlast[i]), 64'((i % OW) == OW - 1));
    end
    check("rand_final_credits", 64'(credits), 64'(0));
    check("rand_no_underflow", 64'(err_underflow), 64'(0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dec_frame_sched.md
Name: dec_frame_sched

Overview:
- Frame scheduler between the channel-data source and decoder_top.
- Groups the incoming 64-bit LLR word stream into fixed-length frames and writes them into the decoder rx data FIFO, honouring rx_dat_fifo_full.
- Limits frames in flight inside the decoder with a credit counter.
- Drains the decoder tx data FIFO into a registered valid/ready output, marking frame ends; each completed output frame returns one credit.

Parameters:
- FRAME_WORDS, 262: 64-bit input words per coded frame.
- OUT_WORDS, 8: 64-bit decoded words per frame read from the tx FIFO.
- MAX_INFLIGHT, 2: maximum frames loaded but not yet fully drained.
- GAP_CYCLES, 4: idle cycles forced between consecutive input frames; 0 means no gap.

Ports:
- clk_dp  in  1  datapath clock (62.5 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits starting new input frames
- s_data  in  64  input LLR word
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid & s_ready
- rx_dat_fifo_wren  out  1  decoder rx FIFO write enable
- rx_dat_fifo_din  out  64  decoder rx FIFO write data
- rx_dat_fifo_full  in  1  decoder rx FIFO full
- tx_dat_fifo_rden  out  1  decoder tx FIFO read enable (FWFT FIFO)
- tx_dat_fifo_dout  in  64  decoder tx FIFO head word
- tx_dat_fifo_empty  in  1  decoder tx FIFO empty
- m_data  out  64  decoded output word (registered)
- m_valid  out  1  output valid
- m_last  out  1  last word of the decoded frame
- m_ready  in  1  downstream ready
- credits  out  $clog2(MAX_INFLIGHT+1)  frames in flight
- busy  out  1  credits != 0 or input FSM not in IDLE
- err_underflow  out  1  sticky: output frame completed while credits == 0

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, all counters = 0. Reset is asynchronous; any in-progress frame is discarded and nothing is written after reset asserts.
- Input FSM states: IDLE, LOAD, GAP.
  - IDLE → LOAD when enable && credits < MAX_INFLIGHT.
  - LOAD: each accepted word increments wcnt. The accept on wcnt == FRAME_WORDS-1 clears wcnt, increments credits, and goes to GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: counts GAP_CYCLES cycles, then → IDLE.
- Once LOAD is entered, dropping enable does not abort the frame. The frame completes and the FSM stops in IDLE.
- s_ready = (state == LOAD) && !rx_dat_fifo_full.
- rx_dat_fifo_wren = s_valid && s_ready and rx_dat_fifo_din = s_data, both combinational with zero latency. No write ever occurs while full is high.
- Output stage (independent of the input FSM):
  - tx_dat_fifo_rden = !tx_dat_fifo_empty && (!m_valid || m_ready).
  - On rden, m_data <= dout and m_valid <= 1, with m_last <= (ocnt == OUT_WORDS-1).
  - When m_valid && m_ready and no rden, m_valid <= 0.
  - Latency: one cycle from the FIFO head to m_valid.
- Output frame count: ocnt increments on each rden and wraps to 0 after OUT_WORDS-1.
- Credit return: when m_valid && m_ready && m_last, credits decrements. If credits == 0 at that point, credits stays 0 and err_underflow is set; err_underflow is cleared only by reset.
- Simultaneous credit increment and decrement in the same cycle leave credits unchanged.
- credits never exceeds MAX_INFLIGHT, because LOAD is not entered at the limit.
- Counter widths: wcnt is $clog2(FRAME_WORDS); ocnt is $clog2(OUT_WORDS), minimum 1 bit.

Optional Feature:
- Macro: DEC_SCHED_STATS_EN.
- Defined: adds outputs stat_frames_in (32 bits), stat_frames_out (32 bits) and stat_full_stall (32 bits). stat_full_stall counts cycles with state == LOAD && s_valid && rx_dat_fifo_full. All three wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dec_pkg: FSM state typedef (IDLE/LOAD/GAP), DEC_WORD_W = 64, default frame-size constants.
- One sub-module, dec_out_stage: the tx FIFO read, output register and ocnt/m_last logic. It exports frame_done to the parent for credit return.

Test Plan (FRAME_WORDS=4, OUT_WORDS=2, MAX_INFLIGHT=2, GAP_CYCLES=3):
- Basic load: enable=1, s_valid=1, data 0x1..0x4 → four consecutive wren with din 0x1..0x4; credits becomes 1 the cycle after the 4th word; s_ready low for exactly 3 GAP cycles plus 1 IDLE cycle.
- Full backpressure: rx_dat_fifo_full high for 5 cycles mid-frame → s_ready=0 and wren=0 during those cycles; no word lost or duplicated; wcnt resumes at the same word.
- Credit limit: load 2 frames with no tx data → credits=2, FSM holds IDLE, s_ready=0. Push 2 tx words and drain with m_ready=1 → m_last on word 2, credits=1, third frame starts.
- Output backpressure: tx FIFO holds 0xA, 0xB and m_ready=0 → m_valid=1, m_data=0xA held, a single rden issued. Raise m_ready → 0xB follows next cycle with m_last=1.
- Simultaneous events: 4th input word accepted in the same cycle as an m_last handshake with credits=1 → credits stays 1. Drain an extra frame at credits=0 → err_underflow=1 and credits stays 0.
- Reset mid-frame: assert rst_n=0 after 2 words → all outputs 0 asynchronously. After release, the next frame starts at wcnt=0 with credits=0.
